ram_dp_port_arbiter: RTL and testbench
======================================

Name: ram_dp_port_arbiter

Overview:
- Controller that sits in front of ram_dp_async_read: one synchronous write port (active-low we_n), one asynchronous read port.
- Shares both RAM ports between two requesters (0 and 1), each with a valid/ready handshake.
- Round-robin arbitration, kept independently for the write port and the read port.
- Sequences a zero-fill of the whole RAM after reset and on request; read data is returned registered.

Parameters:
WIDTH, 8, data width; must match the RAM.
DEPTH, 16, number of RAM words; DEPTH_LOG = $clog2(DEPTH).
INIT_VALUE, 0, WIDTH-bit word written to every address during a clear.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
clr_start  in  1  one-cycle pulse; requests a full RAM clear (ignored unless in RUN).
init_done  out  1  high when in RUN, low during CLEAR.
wr_valid  in  2  per-requester write request.
wr_ready  out  2  per-requester write accept; accepted when valid&ready at posedge.
wr_addr0, wr_addr1  in  DEPTH_LOG  write address per requester.
wr_data0, wr_data1  in  WIDTH  write data per requester.
rd_valid  in  2  per-requester read request.
rd_ready  out  2  per-requester read accept.
rd_addr0, rd_addr1  in  DEPTH_LOG  read address per requester.
rd_rvalid  out  2  one-cycle pulse carrying read response per requester.
rd_rdata  out  WIDTH  registered read data, qualified by rd_rvalid.
ram_we_n  out  1  to RAM we_n; 0 = write at posedge.
ram_addr_wr  out  DEPTH_LOG  to RAM addr_wr.
ram_data_wr  out  WIDTH  to RAM data_wr.
ram_addr_rd  out  DEPTH_LOG  to RAM addr_rd.
ram_data_rd  in  WIDTH  from RAM data_rd (combinational from ram_addr_rd).

Behaviour:
- FSM states: CLEAR, RUN. rst=1 forces state CLEAR, clear counter 0, both RR pointers to "prefer 0", rd_rvalid=0, rd_rdata=0.
- While rst is asserted, all outputs are forced: wr_ready=rd_ready=0, ram_we_n=1, init_done=0.
- CLEAR:
  - ram_we_n=0, ram_addr_wr=counter, ram_data_wr=INIT_VALUE.
  - All readies are 0; clr_start is ignored.
  - counter increments each cycle. At counter==DEPTH-1 the state moves to RUN.
  - A clear lasts exactly DEPTH cycles; init_done rises in the cycle after the last clear write.
  - rst during CLEAR restarts the clear at address 0.
- RUN, clr_start=1: move to CLEAR at the next edge. In that cycle all readies are 0 and ram_we_n=1 (clear has priority; no grant).
- RUN, write port:
  - Grant is combinational. A single valid gets wr_ready.
  - If both are valid, the requester not granted most recently wins.
  - Grant drives ram_we_n=0, ram_addr_wr and ram_data_wr from the winner; the RAM writes at that posedge.
  - The pointer updates only on an accepted write. With no grant, ram_we_n=1.
- RUN, read port:
  - Same round-robin rule with an independent pointer. Grant drives ram_addr_rd = winner address.
  - At posedge: rd_rdata <= ram_data_rd and rd_rvalid[winner] <= 1; other rd_rvalid bits <= 0.
  - Latency is 1 cycle from accept to rd_rvalid. Back-to-back reads give one response per cycle.
- Idle read port: ram_addr_rd holds its last value (0 after reset); rd_rdata holds; rd_rvalid=0.
- Same-cycle write and read to the same address: the read returns the old (pre-write) data. Write data is visible to reads accepted in a later cycle.
- Write and read grants are independent: both ports may serve different requesters (or the same one) in one cycle.
- ready never depends on the requester's own valid beyond the arbitration decision; a non-granted requester holds valid/addr/data until accepted.

Test Plan:
- Reset, DEPTH=16: rst high 2 cycles then low -> ram_we_n=0 for exactly 16 cycles, addresses 0..15, data 00. init_done rises on the 17th cycle. Reading any address afterwards returns 00.
- Single writer: requester 0 writes 5A to addr 5, then reads addr 5 -> rd_rvalid=01 one cycle after the read accept, rd_rdata=5A.
- Write contention: both requesters hold wr_valid for 4 cycles (r0 to addr 2 with 25, r1 to addr 3 with 3A) -> grants alternate 0,1,0,1 starting with 0. Memory ends with addr2=25, addr3=3A.
- Read contention plus same-address hazard: addr 7=7A. In one cycle r0 writes 7B to addr 7 while r1 reads addr 7 -> rd_rdata=7A. The next r1 read of addr 7 returns 7B.
- clr_start in RUN with both wr_valid high -> no grants that cycle, init_done low for 16 cycles, all words 00 afterwards. rst asserted at clear counter 9 -> the clear restarts at address 0.
- Random: 16 writes of (addr<<4)|(addr odd ? A : 5) to random addresses from alternating requesters, each read back -> 16/16 matches and no lost or duplicated rd_rvalid pulses.

Source files
------------

// File: rtl/ram_dp_port_arbiter.sv
// Two-requester front end for a dual-port RAM (sync write, async read) with round-robin grants and a zero-fill sequencer.
// Grants are combinational; read data returns one cycle after accept; unserved requesters hold until granted.
module ram_dp_port_arbiter #(
    parameter int                WIDTH      = 8,
    parameter int                DEPTH      = 16,
    parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
    parameter int                DEPTH_LOG  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_start,
    output logic                 init_done,
    input  logic [1:0]           wr_valid,
    output logic [1:0]           wr_ready,
    input  logic [DEPTH_LOG-1:0] wr_addr0,
    input  logic [DEPTH_LOG-1:0] wr_addr1,
    input  logic [WIDTH-1:0]     wr_data0,
    input  logic [WIDTH-1:0]     wr_data1,
    input  logic [1:0]           rd_valid,
    output logic [1:0]           rd_ready,
    input  logic [DEPTH_LOG-1:0] rd_addr0,
    input  logic [DEPTH_LOG-1:0] rd_addr1,
    output logic [1:0]           rd_rvalid,
    output logic [WIDTH-1:0]     rd_rdata,
    output logic                 ram_we_n,
    output logic [DEPTH_LOG-1:0] ram_addr_wr,
    output logic [WIDTH-1:0]     ram_data_wr,
    output logic [DEPTH_LOG-1:0] ram_addr_rd,
    input  logic [WIDTH-1:0]     ram_data_rd
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [DEPTH_LOG-1:0] clr_cnt;
    logic [DEPTH_LOG-1:0] clr_cnt_nxt;
    logic                 wr_pref;
    logic                 rd_pref;
    logic [1:0]           wr_gnt;
    logic [1:0]           rd_gnt;
    logic [DEPTH_LOG-1:0] rd_addr_q;

    // pref = 1 means requester 1 wins a tie (requester 0 was served last).
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic pref);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = pref ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            wr_pref   <= 1'b0;
            rd_pref   <= 1'b0;
            rd_rvalid <= '0;
            rd_rdata  <= '0;
            rd_addr_q <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            rd_rvalid <= rd_gnt;
            if (wr_gnt != 2'b00) begin
                wr_pref <= wr_gnt[0];
            end
            if (rd_gnt != 2'b00) begin
                rd_pref   <= rd_gnt[0];
                rd_rdata  <= ram_data_rd;
                rd_addr_q <= ram_addr_rd;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_gnt      = 2'b00;
        rd_gnt      = 2'b00;
        init_done   = 1'b0;
        ram_we_n    = 1'b1;
        ram_addr_wr = '0;
        ram_data_wr = '0;
        ram_addr_rd = rd_addr_q;

        if (!rst) begin
            case (state)
                CLEAR: begin
                    ram_we_n    = 1'b0;
                    ram_addr_wr = clr_cnt;
                    ram_data_wr = INIT_VALUE;
                    if (clr_cnt == LAST_ADDR) begin
                        state_nxt   = RUN;
                        clr_cnt_nxt = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    init_done = 1'b1;
                    // A clear request wins the cycle outright; nobody is granted.
                    if (clr_start) begin
                        state_nxt   = CLEAR;
                        clr_cnt_nxt = '0;
                    end else begin
                        wr_gnt = rr_pick(wr_valid, wr_pref);
                        rd_gnt = rr_pick(rd_valid, rd_pref);
                    end
                end
                default: begin
                    state_nxt = CLEAR;
                end
            endcase
        end

        if (wr_gnt[0]) begin
            ram_we_n    = 1'b0;
            ram_addr_wr = wr_addr0;
            ram_data_wr = wr_data0;
        end else if (wr_gnt[1]) begin
            ram_we_n    = 1'b0;
            ram_addr_wr = wr_addr1;
            ram_data_wr = wr_data1;
        end

        if (rd_gnt[0]) begin
            ram_addr_rd = rd_addr0;
        end else if (rd_gnt[1]) begin
            ram_addr_rd = rd_addr1;
        end

        wr_ready = wr_gnt;
        rd_ready = rd_gnt;
    end

endmodule

// File: tb/tb_ram_dp_port_arbiter.sv
// Directed bench for ram_dp_port_arbiter with a behavioural RAM and a read-response scoreboard.
module tb_ram_dp_port_arbiter;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          init_done;
    logic [1:0]    wr_valid;
    logic [1:0]    wr_ready;
    logic [AW-1:0] wr_addr0;
    logic [AW-1:0] wr_addr1;
    logic [W-1:0]  wr_data0;
    logic [W-1:0]  wr_data1;
    logic [1:0]    rd_valid;
    logic [1:0]    rd_ready;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [1:0]    rd_rvalid;
    logic [W-1:0]  rd_rdata;
    logic          ram_we_n;
    logic [AW-1:0] ram_addr_wr;
    logic [W-1:0]  ram_data_wr;
    logic [AW-1:0] ram_addr_rd;
    logic [W-1:0]  ram_data_rd;

    always #5 clk = ~clk;

    ram_dp_port_arbiter #(
        .WIDTH     (W),
        .DEPTH     (D),
        .INIT_VALUE(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_start  (clr_start),
        .init_done  (init_done),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr0   (wr_addr0),
        .wr_addr1   (wr_addr1),
        .wr_data0   (wr_data0),
        .wr_data1   (wr_data1),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .rd_rvalid  (rd_rvalid),
        .rd_rdata   (rd_rdata),
        .ram_we_n   (ram_we_n),
        .ram_addr_wr(ram_addr_wr),
        .ram_data_wr(ram_data_wr),
        .ram_addr_rd(ram_addr_rd),
        .ram_data_rd(ram_data_rd)
    );

    // RAM behind the arbiter: synchronous write, combinational read.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (!ram_we_n) mem[ram_addr_wr] <= ram_data_wr;
    end
    assign ram_data_rd = mem[ram_addr_rd];

    logic [W-1:0] ref_mem [D];
    logic [9:0]   sb [$];
    int           n_pass   = 0;
    int           n_total  = 0;
    int           push_cnt = 0;
    int           resp_cnt = 0;
    bit           wr_pref  = 1'b0;
    bit           rd_pref  = 1'b0;

    function automatic logic [1:0] rr(input logic [1:0] v, input bit pref);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return pref ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            resp_cnt++;
            check("rd_rvalid", 32'(rd_rvalid), 32'(e[9:8]));
            check("rd_rdata", 32'(rd_rdata), 32'(e[7:0]));
        end else if (rd_rvalid != 2'b00) begin
            check("rd_rvalid_spurious", 32'(rd_rvalid), 32'd0);
        end
    endtask

    task automatic cyc(input logic [1:0] wv, input logic [1:0] rv, input string tag);
        logic [1:0]    ew;
        logic [1:0]    er;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [W-1:0]  wd;
        wr_valid = wv;
        rd_valid = rv;
        #1;
        ew = rr(wv, wr_pref);
        er = rr(rv, rd_pref);
        check({tag, ":wr_ready"}, 32'(wr_ready), 32'(ew));
        check({tag, ":rd_ready"}, 32'(rd_ready), 32'(er));
        check({tag, ":ram_we_n"}, 32'(ram_we_n), 32'(ew == 2'b00));
        if (ew != 2'b00) begin
            wa = ew[0] ? wr_addr0 : wr_addr1;
            wd = ew[0] ? wr_data0 : wr_data1;
            check({tag, ":ram_addr_wr"}, 32'(ram_addr_wr), 32'(wa));
            check({tag, ":ram_data_wr"}, 32'(ram_data_wr), 32'(wd));
        end
        if (er != 2'b00) begin
            ra = er[0] ? rd_addr0 : rd_addr1;
            check({tag, ":ram_addr_rd"}, 32'(ram_addr_rd), 32'(ra));
            sb.push_back({er, ref_mem[ra]});
            push_cnt++;
            rd_pref = er[0];
        end
        // Read expectation is taken before the write lands: same-cycle read sees old data.
        if (ew != 2'b00) begin
            ref_mem[wa] = wd;
            wr_pref = ew[0];
        end
        tick();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
    endtask

    task automatic clear_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 2'b11;
            rd_valid = 2'b11;
            #1;
            check("clr:init_done", 32'(init_done), 32'd0);
            check("clr:ram_we_n", 32'(ram_we_n), 32'd0);
            check("clr:ram_addr_wr", 32'(ram_addr_wr), 32'(i));
            check("clr:ram_data_wr", 32'(ram_data_wr), 32'h00);
            check("clr:readies", 32'({wr_ready, rd_ready}), 32'd0);
            tick();
        end
    endtask

    task automatic clear_done();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        #1;
        check("clr_end:init_done", 32'(init_done), 32'd1);
        check("clr_end:ram_we_n", 32'(ram_we_n), 32'd1);
        for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        rst       = 1'b1;
        clr_start = 1'b0;
        wr_valid  = 2'b00;
        rd_valid  = 2'b00;
        wr_addr0  = '0;
        wr_addr1  = '0;
        wr_data0  = '0;
        wr_data1  = '0;
        rd_addr0  = '0;
        rd_addr1  = '0;
        for (int i = 0; i < D; i++) ref_mem[i] = 8'h00;

        // Reset and power-up clear
        #2;
        check("rst:wr_ready", 32'(wr_ready), 32'd0);
        check("rst:rd_ready", 32'(rd_ready), 32'd0);
        check("rst:ram_we_n", 32'(ram_we_n), 32'd1);
        check("rst:init_done", 32'(init_done), 32'd0);
        tick();
        check("rst:rd_rvalid", 32'(rd_rvalid), 32'd0);
        check("rst:rd_rdata", 32'(rd_rdata), 32'd0);
        tick();
        rst = 1'b0;
        clear_cycles(16);
        clear_done();
        rd_addr0 = 4'd0;
        cyc(2'b00, 2'b01, "rd_a0");
        rd_addr1 = 4'd15;
        cyc(2'b00, 2'b10, "rd_a15");

        // Single writer, then read back and idle hold
        wr_addr0 = 4'd5;
        wr_data0 = 8'h5A;
        cyc(2'b01, 2'b00, "w5");
        rd_addr0 = 4'd5;
        cyc(2'b00, 2'b01, "r5");
        cyc(2'b00, 2'b00, "idle");
        check("idle:rd_rvalid", 32'(rd_rvalid), 32'd0);
        check("idle:rd_rdata", 32'(rd_rdata), 32'h5A);
        check("idle:ram_addr_rd", 32'(ram_addr_rd), 32'd5);

        // Write contention: pointer is steered so requester 0 wins first
        wr_addr1 = 4'd9;
        wr_data1 = 8'h9A;
        cyc(2'b10, 2'b00, "w9");
        wr_addr0 = 4'd2;
        wr_data0 = 8'h25;
        wr_addr1 = 4'd3;
        wr_data1 = 8'h3A;
        for (int k = 0; k < 4; k++) begin
            check("wcont:pref", 32'(wr_pref), 32'(k % 2));
            cyc(2'b11, 2'b00, "wcont");
        end
        rd_addr0 = 4'd2;
        rd_addr1 = 4'd3;
        cyc(2'b00, 2'b11, "rcont");
        cyc(2'b00, 2'b11, "rcont");

        // Same-address write/read hazard
        wr_addr0 = 4'd7;
        wr_data0 = 8'h7A;
        cyc(2'b01, 2'b00, "w7a");
        wr_data0 = 8'h7B;
        rd_addr1 = 4'd7;
        cyc(2'b01, 2'b10, "haz");
        cyc(2'b00, 2'b10, "haz_after");

        // clr_start in RUN with everyone requesting
        wr_valid  = 2'b11;
        rd_valid  = 2'b11;
        clr_start = 1'b1;
        #1;
        check("clrst:wr_ready", 32'(wr_ready), 32'd0);
        check("clrst:rd_ready", 32'(rd_ready), 32'd0);
        check("clrst:ram_we_n", 32'(ram_we_n), 32'd1);
        check("clrst:init_done", 32'(init_done), 32'd1);
        tick();
        clr_start = 1'b0;
        clear_cycles(16);
        clear_done();
        rd_addr0 = 4'd5;
        cyc(2'b00, 2'b01, "post_clr5");
        rd_addr1 = 4'd7;
        cyc(2'b00, 2'b10, "post_clr7");
        rd_addr0 = 4'd2;
        cyc(2'b00, 2'b01, "post_clr2");

        // Reset in the middle of a clear
        wr_addr1 = 4'd1;
        wr_data1 = 8'hC3;
        cyc(2'b10, 2'b00, "w1");
        rd_addr0 = 4'd1;
        cyc(2'b00, 2'b01, "r1");
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clear_cycles(9);
        #1;
        check("midclr:ram_addr_wr", 32'(ram_addr_wr), 32'd9);
        check("midclr:rd_rdata", 32'(rd_rdata), 32'hC3);
        rst = 1'b1;
        #1;
        check("midrst:ram_we_n", 32'(ram_we_n), 32'd1);
        check("midrst:init_done", 32'(init_done), 32'd0);
        check("midrst:wr_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_pref = 1'b0;
        rd_pref = 1'b0;
        check("midrst:rd_rdata", 32'(rd_rdata), 32'd0);
        check("midrst:rd_rvalid", 32'(rd_rvalid), 32'd0);
        rst = 1'b0;
        clear_cycles(16);
        clear_done();

        // Random write/readback from alternating requesters
        for (int k = 0; k < 16; k++) begin
            a = 4'($urandom_range(0, 15));
            d = {a, (a[0] ? 4'hA : 4'h5)};
            if (k % 2 == 0) begin
                wr_addr0 = a;
                wr_data0 = d;
                cyc(2'b01, 2'b00, "rnd_w");
                rd_addr0 = a;
                cyc(2'b00, 2'b01, "rnd_r");
            end else begin
                wr_addr1 = a;
                wr_data1 = d;
                cyc(2'b10, 2'b00, "rnd_w");
                rd_addr1 = a;
                cyc(2'b00, 2'b10, "rnd_r");
            end
        end
        cyc(2'b00, 2'b00, "drain");

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("resp_count", 32'(resp_cnt), 32'(push_cnt));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
